// File: rtl/data_bus_pkg.sv
// Shared types and constants for the core-to-system data bus bridge.
package data_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } bus_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replicated data, misalignment, and
// load-lane extraction with sign or zero extension.
module mem_lane_align
    import data_bus_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic zext);
        logic signed [31:0] s32;
        s32 = $signed(b);
        return zext ? {24'd0, b} : s32;
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic zext);
        logic signed [31:0] s32;
        s32 = $signed(h);
        return zext ? {16'd0, h} : s32;
    endfunction

    // Size code 3 falls into the default branch and behaves as a word.
    always_comb begin
        wstrb      = 4'b1111;
        wdata      = st_data;
        misaligned = 1'b0;
        case (st_size)
            SIZE_BYTE: begin
                wstrb = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SIZE_HALF: begin
                wstrb      = 4'b0011 << st_addr_lo;
                wdata      = {2{st_data[15:0]}};
                misaligned = st_addr_lo[0];
            end
            default: begin
                misaligned = (st_addr_lo != 2'b00);
            end
        endcase
    end

    always_comb begin
        case (ld_size)
            SIZE_BYTE: ld_data = extend_byte(ld_word[{ld_addr_lo, 3'b000} +: 8], ld_unsigned);
            SIZE_HALF: ld_data = extend_half(ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0],
                                             ld_unsigned);
            default:   ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/data_bus_bridge.sv
// Converts single-cycle core load/store strobes into a valid/ready request
// and response handshake on the system data bus, stalling the core meanwhile.
module data_bus_bridge
    import data_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [31:0] RESET_RDATA    = 32'h0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_address,
    input  logic [31:0] core_write_data,
    input  logic        core_read,
    input  logic        core_write,
    input  logic [1:0]  core_size,
    input  logic        core_unsigned,
    output logic [31:0] core_read_data,
    output logic        core_wait,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_rready,
    output logic        err_misaligned,
    output logic        err_timeout
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    bus_state_t  state;
    logic [31:0] count;
    logic [29:0] word_addr;
    logic        is_write;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [31:0] read_data_q;
    logic        err_mis_q;
    logic        err_to_q;

    logic        request;
    logic        timeout_hit;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        al_mis;
    logic [31:0] al_ld;

    assign request = core_read | core_write;
    // Compare with >= so a request accepted on the last REQ cycle still
    // respects the overall budget during WAIT_RSP instead of wrapping.
    assign timeout_hit = TO_EN && (count >= TO_LAST);

    mem_lane_align u_align (
        .st_addr_lo  (core_address[1:0]),
        .st_size     (core_size),
        .st_data     (core_write_data),
        .ld_addr_lo  (addr_lo_q),
        .ld_size     (size_q),
        .ld_unsigned (unsigned_q),
        .ld_word     (bus_rdata),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .misaligned  (al_mis),
        .ld_data     (al_ld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            word_addr   <= '0;
            is_write    <= 1'b0;
            size_q      <= 2'd0;
            unsigned_q  <= 1'b0;
            addr_lo_q   <= 2'd0;
            wstrb_q     <= 4'd0;
            wdata_q     <= '0;
            read_data_q <= RESET_RDATA;
            err_mis_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            err_mis_q <= 1'b0;
            err_to_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        // A simultaneous load and store performs the store.
                        word_addr  <= core_address[31:2];
                        is_write   <= core_write;
                        size_q     <= core_size;
                        unsigned_q <= core_unsigned;
                        addr_lo_q  <= core_address[1:0];
                        wstrb_q    <= core_write ? al_wstrb : 4'b0000;
                        wdata_q    <= al_wdata;
                        count      <= '0;
                        if (al_mis) begin
                            state     <= DONE;
                            err_mis_q <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    count <= count + 32'd1;
                    if (bus_ready) begin
                        state <= WAIT_RSP;
                    end else if (timeout_hit) begin
                        state    <= DONE;
                        err_to_q <= 1'b1;
                        if (!is_write) read_data_q <= RESET_RDATA;
                    end
                end
                WAIT_RSP: begin
                    count <= count + 32'd1;
                    if (bus_rvalid) begin
                        state <= DONE;
                        if (!is_write) read_data_q <= al_ld;
                    end else if (timeout_hit) begin
                        state    <= DONE;
                        err_to_q <= 1'b1;
                        if (!is_write) read_data_q <= RESET_RDATA;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign core_wait      = ((state == IDLE) && request) || (state == REQ) || (state == WAIT_RSP);
    assign bus_valid      = (state == REQ);
    assign bus_rready     = (state == WAIT_RSP);
    assign bus_address    = {word_addr, 2'b00};
    assign bus_write      = is_write;
    assign bus_wdata      = wdata_q;
    assign bus_wstrb      = wstrb_q;
    assign core_read_data = read_data_q;
    assign err_misaligned = err_mis_q;
    assign err_timeout    = err_to_q;

endmodule
